// File: rtl/plab4_net_router_input_ctrl_sep.sv
// plab4_net_router_input_ctrl_sep
//   Input-side controller for one ring-router input port. Buffers incoming
//   messages with their security-domain bit in a small FIFO. Routes the head
//   message west (p0), to the terminal (p1) or east (p2) by shortest ring
//   distance, with a tie going east. Raises a single request with the head
//   domain and dequeues when the requested output controller grants.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_val/in_rdy/in_msg/in_domain  upstream enqueue interface
//   reqs_p{0,1,2}                   one-hot (or zero) requests to output ctrls
//   reqs_p{0,1,2}_domain            head domain on the asserted request only
//   grants_p{0,1,2}                 grants from output ctrls
//   out_msg/out_domain              head entry driven to the crossbar
module plab4_net_router_input_ctrl_sep #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_nbits  = 3,
  parameter int p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_domain,

  output logic                   reqs_p0,
  output logic                   reqs_p1,
  output logic                   reqs_p2,
  output logic                   reqs_p0_domain,
  output logic                   reqs_p1_domain,
  output logic                   reqs_p2_domain,

  input  logic                   grants_p0,
  input  logic                   grants_p1,
  input  logic                   grants_p2,

  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_domain
);

  localparam int c_ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int c_cnt_w = $clog2(p_num_entries + 1);

  localparam logic [p_dest_nbits-1:0] c_id   = p_dest_nbits'(p_router_id);
  localparam logic [p_dest_nbits-1:0] c_half = p_dest_nbits'(p_num_routers / 2);
  localparam logic [c_cnt_w-1:0]      c_full = c_cnt_w'(p_num_entries);

  typedef enum logic [1:0] {
    ROUTE_P0,
    ROUTE_P1,
    ROUTE_P2
  } route_t;

  logic [p_msg_nbits-1:0]  buf_msg [p_num_entries];
  logic [p_num_entries-1:0] buf_domain;

  logic [c_ptr_w-1:0] enq_ptr;
  logic [c_ptr_w-1:0] deq_ptr;
  logic [c_cnt_w-1:0] count;

  logic                    empty;
  logic                    enq;
  logic                    deq;
  logic [p_msg_nbits-1:0]  head_msg;
  logic                    head_domain;
  logic [p_dest_nbits-1:0] head_dest;
  logic [p_dest_nbits-1:0] fwd;
  route_t                  route;

  assign empty  = (count == '0);
  assign in_rdy = (count != c_full);
  assign enq    = in_val && in_rdy;

  assign head_msg    = buf_msg[deq_ptr];
  assign head_domain = buf_domain[deq_ptr];
  assign head_dest   = head_msg[p_msg_nbits-1 -: p_dest_nbits];

  // Forward ring distance; the subtraction wraps naturally in dest width
  // because the ring size is a power of two.
  assign fwd = head_dest - c_id;

  always_comb begin
    route = ROUTE_P0;
    if (fwd == '0)
      route = ROUTE_P1;
    else if (fwd <= c_half)
      route = ROUTE_P2;
  end

  always_comb begin
    reqs_p0 = 1'b0;
    reqs_p1 = 1'b0;
    reqs_p2 = 1'b0;
    if (!empty) begin
      case (route)
        ROUTE_P1: reqs_p1 = 1'b1;
        ROUTE_P2: reqs_p2 = 1'b1;
        default:  reqs_p0 = 1'b1;
      endcase
    end
  end

  assign reqs_p0_domain = reqs_p0 && head_domain;
  assign reqs_p1_domain = reqs_p1 && head_domain;
  assign reqs_p2_domain = reqs_p2 && head_domain;

  assign out_msg    = head_msg;
  assign out_domain = !empty && head_domain;

  // Requests are zero when empty, so a grant while empty never dequeues.
  assign deq = (reqs_p0 && grants_p0) || (reqs_p1 && grants_p1)
            || (reqs_p2 && grants_p2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      enq_ptr <= '0;
      deq_ptr <= '0;
    end else begin
      if (enq)
        enq_ptr <= enq_ptr + 1'b1;
      if (deq)
        deq_ptr <= deq_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_msg[enq_ptr]    <= in_msg;
      buf_domain[enq_ptr] <= in_domain;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
module tb_plab4_net_router_input_ctrl_sep;

  localparam int ID    = 0;
  localparam int N     = 8;
  localparam int MW    = 44;
  localparam int DW    = 3;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [MW-1:0] in_msg = '0;
  logic          in_domain = 1'b0;
  logic          reqs_p0, reqs_p1, reqs_p2;
  logic          reqs_p0_domain, reqs_p1_domain, reqs_p2_domain;
  logic          grants_p0 = 1'b0, grants_p1 = 1'b0, grants_p2 = 1'b0;
  logic [MW-1:0] out_msg;
  logic          out_domain;

  plab4_net_router_input_ctrl_sep #(
    .p_router_id  (ID),
    .p_num_routers(N),
    .p_msg_nbits  (MW),
    .p_dest_nbits (DW),
    .p_num_entries(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_val        (in_val),
    .in_rdy        (in_rdy),
    .in_msg        (in_msg),
    .in_domain     (in_domain),
    .reqs_p0       (reqs_p0),
    .reqs_p1       (reqs_p1),
    .reqs_p2       (reqs_p2),
    .reqs_p0_domain(reqs_p0_domain),
    .reqs_p1_domain(reqs_p1_domain),
    .reqs_p2_domain(reqs_p2_domain),
    .grants_p0     (grants_p0),
    .grants_p1     (grants_p1),
    .grants_p2     (grants_p2),
    .out_msg       (out_msg),
    .out_domain    (out_domain)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int xfer_cnt = 0;

  // Reference FIFO contents: messages and domains in arrival order.
  logic [MW-1:0] mq[$];
  logic          md[$];

  wire [2:0] reqs  = {reqs_p2, reqs_p1, reqs_p0};
  wire [2:0] rdoms = {reqs_p2_domain, reqs_p1_domain, reqs_p0_domain};
  wire [2:0] grts  = {grants_p2, grants_p1, grants_p0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Port index from shortest ring distance: 1 = terminal, 2 = east, 0 = west.
  function automatic int route_of(input logic [MW-1:0] m);
    int d, fwd;
    d   = int'(m[MW-1 -: DW]);
    fwd = (d - ID + N) % N;
    if (fwd == 0) return 1;
    if (fwd <= N / 2) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] exp_reqs();
    if (mq.size() == 0) return 3'b000;
    return 3'b001 << route_of(mq[0]);
  endfunction

  function automatic logic [MW-1:0] mk(input int dest, input int payload);
    logic [DW-1:0] d;
    d = DW'(dest);
    return {d, (MW-DW)'(payload)};
  endfunction

  // Compare process: check outputs mid-cycle, then advance the model by
  // the effect of the coming rising edge.
  always @(negedge clk) begin
    logic [2:0] er;
    bit do_deq, do_enq;
    if (reset) begin
      chk("rst_reqs", reqs, 3'b000);
      chk("rst_rdoms", rdoms, 3'b000);
      chk("rst_in_rdy", in_rdy, 1'b1);
      chk("rst_out_domain", out_domain, 1'b0);
      mq.delete();
      md.delete();
    end else begin
      er = exp_reqs();
      chk("in_rdy", in_rdy, (mq.size() != DEPTH));
      chk("reqs", reqs, er);
      chk("reqs_domain", rdoms, (mq.size() != 0 && md[0]) ? er : 3'b000);
      chk("out_domain", out_domain, (mq.size() != 0) ? md[0] : 1'b0);
      if (mq.size() != 0) chk("out_msg", out_msg, mq[0]);
      if ((reqs & grts) != 3'b000) xfer_cnt++;
      do_deq = (er & grts) != 3'b000;
      do_enq = in_val && (mq.size() != DEPTH);
      if (do_deq) begin
        void'(mq.pop_front());
        void'(md.pop_front());
      end
      if (do_enq) begin
        mq.push_back(in_msg);
        md.push_back(in_domain);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grants(input logic [2:0] g);
    {grants_p2, grants_p1, grants_p0} = g;
  endtask

  int          dests[4] = '{0, 1, 4, 5};
  logic [2:0]  rexp[4]  = '{3'b010, 3'b100, 3'b100, 3'b001};
  logic        rdom[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [MW-1:0] ma, mb, mc, mdd;

  initial begin
    // Reset and idle
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    chk("idle_in_rdy", in_rdy, 1'b1);
    chk("idle_reqs", reqs, 3'b000);

    // Routing for id 0, ring of 8
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1;
      in_msg = mk(dests[i], 100 + i);
      in_domain = rdom[i];
      chk("req_before_enq", reqs, 3'b000);
      step();
      in_val = 1'b0;
      chk("route", reqs, rexp[i]);
      chk("route_domain", rdoms, rdom[i] ? rexp[i] : 3'b000);
      set_grants(rexp[i]);
      step();
      set_grants(3'b000);
      chk("after_grant", reqs, 3'b000);
    end

    // Withheld grants: fill, hold, then grant while full with in_val high
    ma = mk(3, 7); mb = mk(6, 8); mc = mk(0, 9);
    in_val = 1'b1; in_domain = 1'b0;
    in_msg = ma; step();
    in_msg = mb; step();
    in_msg = mc;
    chk("full_in_rdy", in_rdy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_reqs", reqs, 3'b100);
      chk("hold_msg", out_msg, ma);
      step();
    end
    set_grants(3'b100);
    step();
    set_grants(3'b000);
    chk("freed_in_rdy", in_rdy, 1'b1);
    chk("second_head", out_msg, mb);
    chk("second_route", reqs, 3'b001);
    step();
    in_val = 1'b0;
    chk("refull_in_rdy", in_rdy, 1'b0);
    chk("refull_head", out_msg, mb);
    set_grants(3'b001); step();
    set_grants(3'b010); step();
    set_grants(3'b000);
    chk("drained_reqs", reqs, 3'b000);
    chk("drained_in_rdy", in_rdy, 1'b1);

    // Spurious grant on a non-requested port
    mdd = mk(2, 55);
    in_val = 1'b1; in_msg = mdd; in_domain = 1'b1;
    step();
    in_val = 1'b0;
    set_grants(3'b001);
    step();
    chk("spurious_reqs", reqs, 3'b100);
    chk("spurious_msg", out_msg, mdd);
    chk("spurious_dom", rdoms, 3'b100);
    set_grants(3'b100);
    step();
    set_grants(3'b000);
    chk("spurious_drain", reqs, 3'b000);
    chk("spurious_out_dom", out_domain, 1'b0);

    // Random stream with grants always on the requested port
    xfer_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_val = 1'b1;
      in_msg = mk(int'($urandom_range(0, N - 1)), int'($urandom));
      in_domain = 1'($urandom);
      set_grants(exp_reqs());
      step();
    end
    in_val = 1'b0;
    set_grants(exp_reqs());
    step();
    set_grants(3'b000);
    chk("stream_xfers", xfer_cnt, 16);
    chk("stream_empty", reqs, 3'b000);

    // Reset mid-stream with two entries buffered
    in_val = 1'b1; in_domain = 1'b1;
    in_msg = mk(1, 1); step();
    in_msg = mk(7, 2); step();
    in_val = 1'b0;
    chk("pre_reset_reqs", reqs, 3'b100);
    reset = 1'b1;
    #1;
    chk("async_reqs", reqs, 3'b000);
    chk("async_in_rdy", in_rdy, 1'b1);
    chk("async_out_dom", out_domain, 1'b0);
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("post_reset_reqs", reqs, 3'b000);
    chk("post_reset_in_rdy", in_rdy, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
